spi_flash_responder: RTL and testbench

- SPI flash target model and responder.
- Sits on the far end of the SPI master's spi_sck/spi_ss/spi_mosi/spi_miso pins.
- Runs on the system clock and oversamples the SPI pins.
- Decodes READ (0x03) + 24-bit address, fetches 32-bit words from a backing-memory port and shifts bytes out MSB-first on spi_miso. Lets XIP reads be exercised end to end.

---
 rtl/spi_flash_pkg.sv | 24 ++
 rtl/spi_pin_sync.sv | 41 ++++
 rtl/spi_flash_responder.sv | 212 +++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg
//   Shared types and constants for the SPI flash responder.
//   - state_t     : responder FSM states
//   - DEF_CMD_*   : default opcodes
//   - *_BITS      : field lengths of the READ / FAST_READ frame
package spi_flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_IGNORE
  } state_t;

  localparam logic [7:0] DEF_CMD_READ      = 8'h03;
  localparam logic [7:0] DEF_CMD_FAST_READ = 8'h0B;

  localparam int CMD_BITS   = 8;
  localparam int ADDR_BITS  = 24;
  localparam int DUMMY_BITS = 8;

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync
//   Multi-flop synchronizer for one asynchronous pin, plus rise/fall
//   detection between the last two synchronized samples.
// Ports:
//   clock, reset (async, active-low)
//   pin   : raw asynchronous input
//   sync  : synchronized level
//   rise  : one-cycle pulse, sync went 0->1
//   fall  : one-cycle pulse, sync went 1->0
// RESET_VAL sets the idle level the chain resets to (1 for active-low
// selects so no false assertion is seen after reset).
module spi_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stages;
  logic                   prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stages <= {SYNC_STAGES{RESET_VAL}};
      prev   <= RESET_VAL;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], pin};
      prev   <= stages[SYNC_STAGES-1];
    end
  end

  assign sync = stages[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder
//   SPI flash target model (mode 0). Oversamples the SPI pins on the
//   system clock, decodes READ + 24-bit address and streams 32-bit words
//   fetched from a backing memory port out on spi_miso, MSB first.
// Ports:
//   clock, reset (async, active-low)
//   spi_sck, spi_ss (active-low), spi_mosi : from SPI master (async)
//   spi_miso                               : to SPI master
//   mem_req/mem_addr/mem_ack/mem_rdata     : word fetch port, req held until ack
//   busy      : synchronized select is asserted
//   underrun  : sticky, a data bit was due before its word arrived
// Build option:
//   SPI_FLASH_FAST_READ_EN - also accept CMD_FAST_READ with 8 dummy clocks.
//
// state     | meaning
// ----------+---------------------------------------------------
// ST_IDLE   | select inactive, miso low
// ST_CMD    | shifting 8 opcode bits
// ST_ADDR   | shifting 24 address bits
// ST_DUMMY  | fast read: discarding 8 sck cycles, fetch running
// ST_DATA   | driving word data on each falling sck
// ST_IGNORE | unknown opcode, wait for select release
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int         SYNC_STAGES   = 2,
  parameter logic [7:0] CMD_READ      = DEF_CMD_READ,
  parameter logic [7:0] CMD_FAST_READ = DEF_CMD_FAST_READ
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        spi_sck,
  input  logic        spi_ss,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        underrun
);

`ifdef SPI_FLASH_FAST_READ_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  logic sck_sync, sck_rise, sck_fall;
  logic ss_sync, ss_rise, ss_fall;
  logic mosi_sync, mosi_rise, mosi_fall;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clock(clock), .reset(reset), .pin(spi_sck),
    .sync(sck_sync), .rise(sck_rise), .fall(sck_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clock(clock), .reset(reset), .pin(spi_ss),
    .sync(ss_sync), .rise(ss_rise), .fall(ss_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clock(clock), .reset(reset), .pin(spi_mosi),
    .sync(mosi_sync), .rise(mosi_rise), .fall(mosi_fall)
  );

  // select and mosi are consumed as levels only
  logic unused_edges;
  assign unused_edges = ^{sck_sync, ss_rise, ss_fall, mosi_rise, mosi_fall};

  state_t      state, next_state;
  logic [4:0]  bit_cnt;
  logic [7:0]  cmd_sr;
  logic [23:0] addr_sr;
  logic        fast_sel;

  logic [23:0] fetch_addr;
  logic        discard;
  logic [31:0] cur_word, nxt_word;
  logic        cur_valid, nxt_valid;
  logic [4:0]  bit_idx;

  logic [7:0]  cmd_byte;
  logic [23:0] addr_full;
  logic        cmd_is_read, cmd_is_fast;
  logic        abort, cmd_done, addr_done, dummy_done;
  logic        fetch_phase, issue, load, advance;

  assign busy        = ~ss_sync;
  assign abort       = ss_sync && (state != ST_IDLE);
  assign cmd_byte    = {cmd_sr[6:0], mosi_sync};
  assign addr_full   = {addr_sr[22:0], mosi_sync};
  assign cmd_is_read = (cmd_byte == CMD_READ);
  assign cmd_is_fast = FAST_EN && (cmd_byte == CMD_FAST_READ);
  assign cmd_done    = (state == ST_CMD)   && sck_rise && (bit_cnt == 5'd0);
  assign addr_done   = (state == ST_ADDR)  && sck_rise && (bit_cnt == 5'd0);
  assign dummy_done  = (state == ST_DUMMY) && sck_rise && (bit_cnt == 5'd0);
  assign fetch_phase = (state == ST_DUMMY) || (state == ST_DATA);
  // one request in flight at most; refill whichever of the two slots is empty
  assign issue       = fetch_phase && !ss_sync && !mem_req && (!cur_valid || !nxt_valid);
  // a stale ack (request outlived its transfer) is consumed but not stored
  assign load        = mem_ack && mem_req && !discard && !abort && fetch_phase;
  assign advance     = (state == ST_DATA) && sck_fall && (bit_idx == 5'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (!ss_sync) next_state = ST_CMD;
      ST_CMD:   if (cmd_done) next_state = (cmd_is_read || cmd_is_fast) ? ST_ADDR : ST_IGNORE;
      ST_ADDR:  if (addr_done) next_state = fast_sel ? ST_DUMMY : ST_DATA;
      ST_DUMMY: if (dummy_done) next_state = ST_DATA;
      default:  next_state = state;
    endcase
    if (abort) next_state = ST_IDLE;
  end

  // bit counter counts down to the end of each frame field
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt  <= 5'd0;
      cmd_sr   <= 8'd0;
      addr_sr  <= 24'd0;
      fast_sel <= 1'b0;
    end else begin
      if (next_state != state) begin
        case (next_state)
          ST_CMD:   bit_cnt <= 5'(CMD_BITS - 1);
          ST_ADDR:  bit_cnt <= 5'(ADDR_BITS - 1);
          ST_DUMMY: bit_cnt <= 5'(DUMMY_BITS - 1);
          default:  bit_cnt <= 5'd0;
        endcase
      end else if (sck_rise && (bit_cnt != 5'd0)) begin
        bit_cnt <= bit_cnt - 5'd1;
      end
      if ((state == ST_CMD) && sck_rise)  cmd_sr  <= cmd_byte;
      if ((state == ST_ADDR) && sck_rise) addr_sr <= addr_full;
      if (cmd_done) fast_sel <= cmd_is_fast;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_req    <= 1'b0;
      mem_addr   <= 24'd0;
      fetch_addr <= 24'd0;
      discard    <= 1'b0;
      cur_word   <= 32'd0;
      nxt_word   <= 32'd0;
      cur_valid  <= 1'b0;
      nxt_valid  <= 1'b0;
      bit_idx    <= 5'd0;
      spi_miso   <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      if (mem_ack) begin
        mem_req <= 1'b0;
      end else if (issue) begin
        mem_req    <= 1'b1;
        mem_addr   <= fetch_addr;
        fetch_addr <= fetch_addr + 24'd4;
      end

      if (mem_ack)               discard <= 1'b0;
      else if (abort && mem_req) discard <= 1'b1;

      if (abort) begin
        cur_valid <= 1'b0;
        nxt_valid <= 1'b0;
        spi_miso  <= 1'b0;
      end else begin
        if (addr_done) begin
          fetch_addr <= {addr_full[23:2], 2'b00};
          // first bit is bit 7 of byte addr[1:0], byte 0 being [31:24]
          bit_idx    <= {~addr_full[1:0], 3'b111};
          cur_valid  <= 1'b0;
          nxt_valid  <= 1'b0;
        end

        if ((state == ST_DATA) && sck_fall) begin
          spi_miso <= cur_valid & cur_word[bit_idx];
          if (!cur_valid) underrun <= 1'b1;
          bit_idx <= bit_idx - 5'd1;
        end

        if (advance) begin
          cur_word  <= nxt_word;
          cur_valid <= nxt_valid;
          nxt_valid <= 1'b0;
        end

        // an arriving word fills the oldest empty slot, seen after any advance
        if (load) begin
          if (advance ? !nxt_valid : !cur_valid) begin
            cur_word  <= mem_rdata;
            cur_valid <= 1'b1;
          end else begin
            nxt_word  <= mem_rdata;
            nxt_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
module tb_spi_flash_responder;

  logic        clock;
  logic        reset;
  logic        spi_sck;
  logic        spi_ss;
  logic        spi_mosi;
  logic        spi_miso;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        underrun;

  int total;
  int bad;

  logic [31:0] mem_model [logic [23:0]];
  logic [23:0] addr_log [$];
  int          mem_delay;
  int          wait_cnt;

  spi_flash_responder dut (
    .clock(clock), .reset(reset),
    .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .underrun(underrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_read(input logic [23:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return 32'd0;
  endfunction

  // backing memory: acks after mem_delay cycles of a held request
  always @(negedge clock) begin
    if (!reset) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      if (wait_cnt >= mem_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_read(mem_addr);
        addr_log.push_back(mem_addr);
        wait_cnt  = 0;
      end else begin
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_req_low(input int max_clk, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_clk; i++) begin
      if (!mem_req) begin
        ok = 1'b1;
        break;
      end
      wait_clk(1);
    end
  endtask

  // full mode-0 frame: 8 cmd + 24 addr + n_dummy + n_data clocks
  task automatic xfer(input logic [7:0] cmd, input logic [23:0] addr, input int n_dummy,
                      input int n_data, input int phase, output logic [63:0] rx);
    logic [31:0] hdr;
    hdr = {cmd, addr};
    rx  = 64'd0;
    spi_ss = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 32 + n_dummy + n_data; i++) begin
      spi_mosi = (i < 32) ? hdr[31-i] : 1'b0;
      wait_clk(phase);
      if (i >= 32 + n_dummy) rx = {rx[62:0], spi_miso};
      spi_sck = 1'b1;
      wait_clk(phase);
      spi_sck = 1'b0;
    end
    wait_clk(phase);
    spi_ss   = 1'b1;
    spi_mosi = 1'b0;
    wait_clk(8);
  endtask

  initial begin
    #600000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] rx;
    logic [31:0] hdr;
    int          base;
    bit          ok;

    total    = 0;
    bad      = 0;
    reset    = 1'b0;
    spi_ss   = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    mem_delay = 0;
    wait_clk(3);
    chk_val("rst_miso", spi_miso, 0);
    chk_val("rst_req", mem_req, 0);
    chk_val("rst_addr", mem_addr, 0);
    chk_val("rst_busy", busy, 0);
    chk_val("rst_underrun", underrun, 0);
    reset = 1'b1;
    wait_clk(5);

    // aligned read, one word
    mem_model[24'h000000] = 32'hDEADBEEF;
    base = addr_log.size();
    xfer(8'h03, 24'h000000, 0, 32, 6, rx);
    chk_val("t1_data", rx[31:0], 32'hDEADBEEF);
    chk_val("t1_addr0", addr_log[base], 24'h000000);
    chk_val("t1_underrun", underrun, 0);

    // unaligned start crossing into the prefetched word
    mem_model[24'h000004] = 32'h11223344;
    mem_model[24'h000008] = 32'h55667788;
    base = addr_log.size();
    xfer(8'h03, 24'h000006, 0, 32, 6, rx);
    chk_val("t2_data", rx[31:0], 32'h33445566);
    chk_val("t2_addr0", addr_log[base], 24'h000004);
    chk_val("t2_addr1", addr_log[base+1], 24'h000008);

    // top-of-space wrap
    mem_model[24'hFFFFFC] = 32'hA1A2A3A4;
    mem_model[24'h000000] = 32'hB1B2B3B4;
    base = addr_log.size();
    xfer(8'h03, 24'hFFFFFC, 0, 64, 6, rx);
    chk_val("t3_data", rx, 64'hA1A2A3A4B1B2B3B4);
    chk_val("t3_addr1", addr_log[base+1], 24'h000000);

    // unknown opcode
    base = addr_log.size();
    xfer(8'h9F, 24'h000000, 0, 32, 6, rx);
    chk_val("t4_miso", rx, 64'd0);
    chk_val("t4_nreq", addr_log.size() - base, 0);

    // fast read opcode
    mem_model[24'h000010] = 32'hC0FFEE11;
    base = addr_log.size();
`ifdef SPI_FLASH_FAST_READ_EN
    xfer(8'h0B, 24'h000010, 8, 32, 6, rx);
    chk_val("fast_data", rx[31:0], 32'hC0FFEE11);
    chk_val("fast_addr0", addr_log[base], 24'h000010);
`else
    xfer(8'h0B, 24'h000010, 0, 32, 6, rx);
    chk_val("fast_ignored", rx, 64'd0);
    chk_val("fast_nreq", addr_log.size() - base, 0);
`endif

    // slow memory: first five data bits are due before the word arrives
    mem_model[24'h000040] = 32'hFFFFFFFF;
    mem_delay = 40;
    xfer(8'h03, 24'h000040, 0, 32, 4, rx);
    chk_val("ur_flag", underrun, 1);
    chk_val("ur_head", rx[31:28], 4'h0);
    chk_val("ur_tail", rx[23:0], 24'hFFFFFF);
    wait_req_low(300, ok);

    // select released while the first fetch is still outstanding
    mem_model[24'h000080] = 32'h12345678;
    mem_delay = 200;
    xfer(8'h03, 24'h000080, 0, 4, 6, rx);
    chk_val("ab_req_held", mem_req, 1);
    chk_val("ab_busy", busy, 0);
    chk_val("ab_miso", spi_miso, 0);
    wait_req_low(400, ok);
    chk_val("ab_req_drop", ok, 1);
    mem_delay = 0;

    // reset in the middle of the address phase
    hdr = {8'h03, 24'h000100};
    spi_ss = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 20; i++) begin
      spi_mosi = hdr[31-i];
      wait_clk(6);
      spi_sck = 1'b1;
      wait_clk(6);
      spi_sck = 1'b0;
    end
    wait_clk(2);
    reset = 1'b0;
    #1;
    chk_val("mr_miso", spi_miso, 0);
    chk_val("mr_req", mem_req, 0);
    chk_val("mr_addr", mem_addr, 0);
    chk_val("mr_busy", busy, 0);
    chk_val("mr_underrun", underrun, 0);
    spi_ss   = 1'b1;
    spi_mosi = 1'b0;
    wait_clk(3);
    reset = 1'b1;
    wait_clk(5);
    mem_model[24'h000100] = 32'hCAFEF00D;
    xfer(8'h03, 24'h000100, 0, 32, 6, rx);
    chk_val("mr_after_data", rx[31:0], 32'hCAFEF00D);
    chk_val("mr_after_ur", underrun, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
